// File: rtl/io_map_pkg.sv
// ----------------------------------------------------------------------------
// io_map_pkg
//   Shared IO address map and IO data-path width for the memory/IO steering
//   stage and the peripherals hanging off it.
//   - SWITCH_DATA_ADDR / SWITCH_FLAG_ADDR : debounced switch level / W1C flags
//   - LED_ADDR_LO / LED_ADDR_HI           : LED output halves
//   - IO_DATA_W                           : width of the IO read/write path
// ----------------------------------------------------------------------------
package io_map_pkg;

    localparam logic [31:0] SWITCH_DATA_ADDR = 32'hFFFF_FC70;
    localparam logic [31:0] SWITCH_FLAG_ADDR = 32'hFFFF_FC72;
    localparam logic [31:0] LED_ADDR_LO      = 32'hFFFF_FC60;
    localparam logic [31:0] LED_ADDR_HI      = 32'hFFFF_FC62;

    localparam int IO_DATA_W = 16;

endpackage

// File: rtl/switch_debounce_bit.sv
// ----------------------------------------------------------------------------
// switch_debounce_bit
//   One switch bit: 2-flop synchronizer, STABLE-deep sample history and the
//   accepted (debounced) level.
//   Ports:
//     clock, reset  : system clock, async active-low reset
//     i_tick        : debounce sample strobe, shifts the history
//     i_accept      : high the cycle after a tick, enables acceptance
//     i_raw         : raw asynchronous switch input
//     o_stable      : accepted level
//     o_changed     : one-cycle pulse, high in the cycle o_stable is updated
// ----------------------------------------------------------------------------
module switch_debounce_bit #(
    parameter int STABLE = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic i_tick,
    input  logic i_accept,
    input  logic i_raw,
    output logic o_stable,
    output logic o_changed
);

    logic [1:0]        r_sync;
    logic [STABLE-1:0] r_hist;
    logic              r_stable;

    logic w_all1;
    logic w_all0;

    assign w_all1 = &r_hist;
    assign w_all0 = ~|r_hist;

    // A full window of equal samples that disagrees with the accepted level
    // flips it; any mixed window leaves everything untouched.
    assign o_changed = i_accept & ((w_all1 & ~r_stable) | (w_all0 & r_stable));
    assign o_stable  = r_stable;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync   <= '0;
            r_hist   <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (i_tick) begin
                r_hist <= {r_hist[STABLE-2:0], r_sync[1]};
            end
            if (o_changed) begin
                r_stable <= ~r_stable;
            end
        end
    end

endmodule

// File: rtl/switch_input_port.sv
// ----------------------------------------------------------------------------
// switch_input_port
//   Debounced switch input peripheral on the IO read path.
//   DATA  (addr1=0): read-only debounced switch levels.
//   FLAGS (addr1=1): sticky per-bit change flags, write-one-to-clear.
//   Ports:
//     clock, reset  : system clock, async active-low reset
//     switchctrl    : chip-select from the steering stage
//     addr1         : 0 = DATA, 1 = FLAGS
//     ioread        : IO read strobe (combinational read, no side effects)
//     iowrite       : IO write strobe (only FLAGS is writable)
//     write_data    : IO write data, 1s clear the matching flags
//     switch_in     : raw board switches
//     ioread_data   : read data, 0 when not selected
// ----------------------------------------------------------------------------
module switch_input_port
    import io_map_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int TICK_DIV = 100000,
    parameter int STABLE   = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 switchctrl,
    input  logic                 addr1,
    input  logic                 ioread,
    input  logic                 iowrite,
    input  logic [IO_DATA_W-1:0] write_data,
    input  logic [WIDTH-1:0]     switch_in,
    output logic [WIDTH-1:0]     ioread_data
);

    // With TICK_DIV=1 the counter never leaves 0, so keep it 1 bit wide.
    localparam int               CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_presc;
    logic             r_accept;
    logic [WIDTH-1:0] r_flag;

    logic             w_tick;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_changed;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_wdata;

    // ---------------- prescaler ----------------
    assign w_tick = (r_presc == CNT_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_presc  <= '0;
            r_accept <= 1'b0;
        end else begin
            r_presc  <= w_tick ? '0 : r_presc + CNT_W'(1);
            // acceptance looks at the history one cycle after it shifted
            r_accept <= w_tick;
        end
    end

    // ---------------- per-bit debounce ----------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce_bit #(
            .STABLE   (STABLE)
        ) u_bit (
            .clock    (clock),
            .reset    (reset),
            .i_tick   (w_tick),
            .i_accept (r_accept),
            .i_raw    (switch_in[i]),
            .o_stable (w_stable[i]),
            .o_changed(w_changed[i])
        );
    end

    // ---------------- sticky flags, W1C ----------------
    assign w_wdata = WIDTH'(write_data);
    assign w_clr   = (iowrite && switchctrl && addr1) ? w_wdata : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_flag <= '0;
        end else begin
            // a change accepted in the same cycle as a clear keeps the flag set
            r_flag <= (r_flag & ~w_clr) | w_changed;
        end
    end

    // ---------------- combinational read mux ----------------
    always_comb begin
        ioread_data = '0;
        if (ioread && switchctrl) begin
            ioread_data = addr1 ? r_flag : w_stable;
        end
    end

endmodule

// File: tb/tb_switch_input_port.sv
module tb_switch_input_port;

    localparam int TD = 4;
    localparam int ST = 3;
    localparam int HN = 8192;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        switchctrl = 1'b0;
    logic        addr1 = 1'b0;
    logic        ioread = 1'b0;
    logic        iowrite = 1'b0;
    logic [15:0] write_data = '0;
    logic [15:0] switch_in = '0;
    logic [15:0] ioread_data;

    switch_input_port #(
        .WIDTH      (16),
        .TICK_DIV   (TD),
        .STABLE     (ST)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .switchctrl (switchctrl),
        .addr1      (addr1),
        .ioread     (ioread),
        .iowrite    (iowrite),
        .write_data (write_data),
        .switch_in  (switch_in),
        .ioread_data(ioread_data)
    );

    always #5 clock = ~clock;

    int nvec = 0;
    int nfail = 0;

    // Reference model: sw_at[m] is the switch value seen at the m-th rising
    // edge after reset release. The accepted level changes at edges that are
    // multiples of TD, using the ST samples taken every TD edges, each
    // 2 synchronizer edges + 1 acceptance edge old.
    logic [15:0] sw_at [0:HN-1];
    int          m = 0;
    logic [15:0] mstable = '0;
    logic [15:0] mflag = '0;

    function automatic logic [15:0] samp(input int j);
        if (j < 0 || j >= HN) return 16'h0000;
        return sw_at[j];
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [15:0] sw, input logic ctrl, input logic a1,
                       input logic rd, input logic wr, input logic [15:0] wd,
                       output logic [15:0] got);
        logic [15:0] exp, andv, orv, s, set, clr;
        switch_in  = sw;
        switchctrl = ctrl;
        addr1      = a1;
        ioread     = rd;
        iowrite    = wr;
        write_data = wd;
        if (!reset) begin
            mstable = '0;
            mflag   = '0;
            m       = 0;
        end
        #1;
        got = ioread_data;
        exp = (rd && ctrl) ? (a1 ? mflag : mstable) : 16'h0000;
        chk("model_read", got, exp);
        @(posedge clock);
        if (reset) begin
            if (m < HN) sw_at[m] = sw;
            set = '0;
            if (m % TD == 0) begin
                andv = '1;
                orv  = '0;
                for (int i = 0; i < ST; i++) begin
                    s    = samp(m - 3 - TD * i);
                    andv = andv & s;
                    orv  = orv | s;
                end
                set = (andv & ~mstable) | (~orv & mstable);
            end
            clr     = (wr && ctrl && a1) ? wd : 16'h0000;
            mstable = mstable ^ set;
            mflag   = (mflag & ~clr) | set;
            m++;
        end
        @(negedge clock);
    endtask

    task automatic rdreg(input logic [15:0] sw, input logic a1, output logic [15:0] got);
        cyc(sw, 1'b1, a1, 1'b1, 1'b0, 16'h0000, got);
    endtask

    task automatic wrflags(input logic [15:0] sw, input logic [15:0] wd);
        logic [15:0] g;
        cyc(sw, 1'b1, 1'b1, 1'b0, 1'b1, wd, g);
    endtask

    task automatic idle(input int n, input logic [15:0] sw);
        logic [15:0] g;
        for (int i = 0; i < n; i++) rdreg(sw, 1'b0, g);
    endtask

    typedef struct {
        logic        ctrl;
        logic        a1;
        logic        rd;
        logic        wr;
        logic [15:0] wd;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [15:0] g;
        logic [15:0] sw;
        int target;

        // state during the table: switches held at 00A5, stable 00A5, flags 00A0
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, "rd_nocs_data"};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, "rd_nocs_flags"};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h00A5, "rd_data"};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h00A0, "rd_flags"};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, "no_strobe"};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h00A5, "wr_data_ignored"};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h00A0, "flags_after_data_wr"};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, "wr_flags_nocs"};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h00A0, "flags_after_nocs_wr"};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h00A0, "rdwr_flags"};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0080, "flags_after_w1c"};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h00A5, "data_final"};

        @(negedge clock);

        // ---- reset with switches high, then debounce after release ----
        for (int i = 0; i < 3; i++) begin
            rdreg(16'hFFFF, 1'b0, g);
            chk("reset_data", g, 16'h0000);
        end
        rdreg(16'hFFFF, 1'b1, g);
        chk("reset_flags", g, 16'h0000);
        reset = 1'b1;
        for (int n = 0; n < 16; n++) begin
            rdreg(16'hFFFF, 1'b0, g);
            if (n < 11)  chk("rst_early_data", g, 16'h0000);
            if (n >= 15) chk("rst_late_data", g, 16'hFFFF);
        end
        rdreg(16'hFFFF, 1'b1, g);
        chk("rst_flags", g, 16'hFFFF);
        wrflags(16'hFFFF, 16'hFFFF);
        rdreg(16'hFFFF, 1'b1, g);
        chk("rst_flags_cleared", g, 16'h0000);

        // ---- bounce on bit 3: toggles every 2 cycles, every tick sample sees 0 ----
        idle(20, 16'h0000);
        wrflags(16'h0000, 16'hFFFF);
        for (int c = 0; c < 40; c++) begin
            sw = ((m % 4) == 2 || (m % 4) == 3) ? 16'h0008 : 16'h0000;
            rdreg(sw, 1'b0, g);
            chk("bounce_data3", {15'b0, g[3]}, 16'h0000);
        end
        idle(16, 16'h0000);
        rdreg(16'h0000, 1'b0, g);
        chk("bounce_data_end", {15'b0, g[3]}, 16'h0000);
        rdreg(16'h0000, 1'b1, g);
        chk("bounce_flag3", {15'b0, g[3]}, 16'h0000);

        // ---- clean change and W1C ----
        idle(16, 16'h00A5);
        rdreg(16'h00A5, 1'b0, g);
        chk("clean_data", g, 16'h00A5);
        rdreg(16'h00A5, 1'b1, g);
        chk("clean_flags", g, 16'h00A5);
        wrflags(16'h00A5, 16'h0005);
        rdreg(16'h00A5, 1'b1, g);
        chk("w1c_flags", g, 16'h00A0);
        rdreg(16'h00A5, 1'b0, g);
        chk("w1c_data", g, 16'h00A5);

        // ---- decode table ----
        for (int i = 0; i < 12; i++) begin
            cyc(16'h00A5, tbl[i].ctrl, tbl[i].a1, tbl[i].rd, tbl[i].wr, tbl[i].wd, g);
            chk(tbl[i].name, g, tbl[i].exp);
        end

        // ---- set/clear collision on bit 8 ----
        // first edge carrying bit 8 is edge m; it is accepted at the first
        // acceptance edge whose whole window lies at or after that edge
        target = ((m + 11 + TD - 1) / TD) * TD;
        while (m < target) begin
            rdreg(16'h01A5, 1'b0, g);
            chk("coll_pre_data8", {15'b0, g[8]}, 16'h0000);
        end
        cyc(16'h01A5, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0100, g);
        chk("coll_pre_flag8", {15'b0, g[8]}, 16'h0000);
        rdreg(16'h01A5, 1'b1, g);
        chk("coll_flag8", {15'b0, g[8]}, 16'h0001);
        rdreg(16'h01A5, 1'b0, g);
        chk("coll_data", g, 16'h01A5);

        // ---- reset in the middle of a debounce window ----
        idle(16, 16'h0000);
        wrflags(16'h0000, 16'hFFFF);
        for (int c = 0; c < 6; c++) begin
            rdreg(16'h0001, 1'b0, g);
            chk("mid_pre_data", g, 16'h0000);
        end
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            rdreg(16'h0001, 1'b1, g);
            chk("mid_reset_flags", g, 16'h0000);
        end
        reset = 1'b1;
        for (int n = 0; n < 16; n++) begin
            rdreg(16'h0001, 1'b0, g);
            if (n < 11)  chk("mid_early_data", g, 16'h0000);
            if (n >= 15) chk("mid_late_data", g, 16'h0001);
        end
        rdreg(16'h0001, 1'b1, g);
        chk("mid_flags", g, 16'h0001);

        // ---- randomized traffic against the model ----
        sw = 16'($urandom);
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 7) == 0) sw = sw ^ (16'($urandom) & 16'($urandom));
            cyc(sw, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                16'($urandom), g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
